// File: rtl/mulseq_pkg.sv
// Shared definitions for the sequential shift/add multiplier:
// state encoding, MUL/MLA opcode values and the default operand width.
package mulseq_pkg;

    localparam int MULSEQ_DATA_W = 32;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_MLA = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mulseq_datapath.sv
// Shift/add datapath: multiplicand, multiplier and running product
// registers plus the captured result. Sequencing comes from mul_sequencer.
module mulseq_datapath
    import mulseq_pkg::*;
#(
    parameter int DATA_W = MULSEQ_DATA_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Load,
    input  logic              Step,
    input  logic              Capture,
    input  logic              OpE,
    input  logic [DATA_W-1:0] SrcA,
    input  logic [DATA_W-1:0] SrcB,
    input  logic [DATA_W-1:0] Acc,
    output logic              NextMplierZero,
    output logic [DATA_W-1:0] Result
);

    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [DATA_W-1:0] product;
    logic [DATA_W-1:0] productNext;
    logic [DATA_W-1:0] mplierNext;

    // One iteration of the add-and-shift step, evaluated every cycle
    always_comb begin
        productNext    = mplier[0] ? (product + mcand) : product;
        mplierNext     = mplier >> 1;
        NextMplierZero = (mplierNext == '0);
    end

    // Operand load on start, iterate in RUN, capture final sum into Result
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            mcand   <= '0;
            mplier  <= '0;
            product <= '0;
            Result  <= '0;
        end else begin
            if (Load) begin
                mcand   <= SrcA;
                mplier  <= SrcB;
                product <= (OpE == OP_MLA) ? Acc : '0;
            end else if (Step) begin
                mcand   <= mcand << 1;
                mplier  <= mplierNext;
                product <= productNext;
            end
            // Capture the last iteration's sum so Result is valid in DONE
            // while product is free to reload for a back-to-back start.
            if (Capture) begin
                Result <= productNext;
            end
        end
    end

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle MUL/MLA sequencer: FSM, iteration counter and pipeline stall
// request around the mulseq_datapath shift/add engine.
// Optional build macro: MULSEQ_EARLY_TERM_EN (finish once the shifted
// multiplier becomes zero instead of always running DATA_W iterations).
module mul_sequencer
    import mulseq_pkg::*;
#(
    parameter int DATA_W = MULSEQ_DATA_W,
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              StartE,
    input  logic              OpE,
    input  logic [DATA_W-1:0] SrcAE,
    input  logic [DATA_W-1:0] SrcBE,
    input  logic [DATA_W-1:0] AccE,
    input  logic [3:0]        WA3E,
    input  logic              KillE,
    output logic              StallReq,
    output logic              Busy,
    output logic              Done,
    output logic [DATA_W-1:0] Result,
    output logic [3:0]        WA3Out
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_DONE = DONE;

`ifdef MULSEQ_EARLY_TERM_EN
    localparam bit EarlyTerm = 1'b1;
`else
    localparam bit EarlyTerm = 1'b0;
`endif

    logic [1:0]       state;
    logic [1:0]       stateNext;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       wa3Lat;
    logic             startOk;
    logic             load;
    logic             step;
    logic             finish;
    logic             capture;
    logic             nextMplierZero;

    // Control strobes for the datapath and termination condition
    always_comb begin
        startOk = StartE & ~KillE;
        load    = startOk & (state != ST_RUN);
        step    = (state == ST_RUN) & ~KillE;
        finish  = (cnt == CNT_W'(DATA_W - 1)) | (EarlyTerm & nextMplierZero);
        capture = step & finish;
    end

    // Next-state logic; a kill in RUN wins over completion
    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE: stateNext = startOk ? ST_RUN : ST_IDLE;
            ST_RUN: begin
                if (KillE) begin
                    stateNext = ST_IDLE;
                end else if (finish) begin
                    stateNext = ST_DONE;
                end
            end
            ST_DONE: stateNext = startOk ? ST_RUN : ST_IDLE;
            default: stateNext = ST_IDLE;
        endcase
    end

    // State, iteration counter and destination register tracking
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            wa3Lat <= '0;
            WA3Out <= '0;
        end else begin
            state <= stateNext;
            if (load) begin
                cnt    <= '0;
                wa3Lat <= WA3E;
            end else if (step) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (capture) begin
                WA3Out <= wa3Lat;
            end
        end
    end

    // Status outputs; forced low while reset is asserted
    always_comb begin
        StallReq = Reset & ((startOk & (state != ST_RUN)) |
                            ((state == ST_RUN) & ~KillE));
        Busy     = Reset & (state == ST_RUN);
        Done     = Reset & (state == ST_DONE);
    end

    mulseq_datapath #(
        .DATA_W(DATA_W)
    ) uDatapath (
        .Clk            (Clk),
        .Reset          (Reset),
        .Load           (load),
        .Step           (step),
        .Capture        (capture),
        .OpE            (OpE),
        .SrcA           (SrcAE),
        .SrcB           (SrcBE),
        .Acc            (AccE),
        .NextMplierZero (nextMplierZero),
        .Result         (Result)
    );

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: directed and random MUL/MLA
// sequences checked against an arithmetic reference model.
module tb_mul_sequencer;

    logic        Clk;
    logic        Reset;
    logic        StartE;
    logic        OpE;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic [31:0] AccE;
    logic [3:0]  WA3E;
    logic        KillE;
    logic        StallReq;
    logic        Busy;
    logic        Done;
    logic [31:0] Result;
    logic [3:0]  WA3Out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] acc;
        logic [3:0]  wa;
    } op_t;

    op_t         ops[$];
    logic [31:0] lastRes;
    logic [3:0]  lastWa;

    mul_sequencer #(.DATA_W(32)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .StartE   (StartE),
        .OpE      (OpE),
        .SrcAE    (SrcAE),
        .SrcBE    (SrcBE),
        .AccE     (AccE),
        .WA3E     (WA3E),
        .KillE    (KillE),
        .StallReq (StallReq),
        .Busy     (Busy),
        .Done     (Done),
        .Result   (Result),
        .WA3Out   (WA3Out)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] expResult(input op_t o);
        logic [31:0] r;
        r = (o.op ? o.acc : 32'd0) + o.a * o.b;
        return r;
    endfunction

    // Number of RUN cycles an operation takes
    function automatic int runLen(input logic [31:0] b);
`ifdef MULSEQ_EARLY_TERM_EN
        int n;
        logic [31:0] v;
        n = 0;
        v = b;
        while (v != 0) begin
            v = v >> 1;
            n++;
        end
        return (n == 0) ? 1 : n;
`else
        return 32;
`endif
    endfunction

    task automatic nextCycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input bit s, input bit k, input op_t o);
        StartE = s;
        KillE  = k;
        OpE    = o.op;
        SrcAE  = o.a;
        SrcBE  = o.b;
        AccE   = o.acc;
        WA3E   = o.wa;
        #1;
    endtask

    task automatic driveIdle(input bit k);
        op_t g;
        g.op  = 1'($urandom);
        g.a   = $urandom;
        g.b   = $urandom;
        g.acc = $urandom;
        g.wa  = 4'($urandom);
        drive(1'b0, k, g);
    endtask

    function automatic op_t mk(input bit op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] acc, input logic [3:0] wa);
        op_t o;
        o.op = op; o.a = a; o.b = b; o.acc = acc; o.wa = wa;
        return o;
    endfunction

    // Runs every queued op back-to-back, starting from IDLE
    task automatic runChain(input bit killAtDone);
        op_t o;
        op_t prev;
        int  len;
        for (int i = 0; i < ops.size(); i++) begin
            o = ops[i];
            drive(1'b1, 1'b0, o);
            if (i == 0) begin
                chk("start_busy", 32'(Busy), 32'd0);
                chk("start_done", 32'(Done), 32'd0);
            end else begin
                chk("b2b_done", 32'(Done), 32'd1);
                chk("b2b_result", Result, expResult(prev));
                chk("b2b_wa", 32'(WA3Out), 32'(prev.wa));
                lastRes = expResult(prev);
                lastWa  = prev.wa;
            end
            chk("start_stall", 32'(StallReq), 32'd1);
            nextCycle();
            len = runLen(o.b);
            for (int c = 1; c <= len; c++) begin
                driveIdle(1'b0);
                chk("run_busy", 32'(Busy), 32'd1);
                chk("run_stall", 32'(StallReq), 32'd1);
                chk("run_done", 32'(Done), 32'd0);
                chk("run_result_hold", Result, lastRes);
                nextCycle();
            end
            prev = o;
        end
        driveIdle(killAtDone);
        chk("done_pulse", 32'(Done), 32'd1);
        chk("done_result", Result, expResult(prev));
        chk("done_wa", 32'(WA3Out), 32'(prev.wa));
        chk("done_busy", 32'(Busy), 32'd0);
        chk("done_stall", 32'(StallReq), 32'd0);
        lastRes = expResult(prev);
        lastWa  = prev.wa;
        nextCycle();
        driveIdle(1'b0);
        chk("post_done", 32'(Done), 32'd0);
        chk("post_busy", 32'(Busy), 32'd0);
        chk("post_result_hold", Result, lastRes);
        chk("post_wa_hold", 32'(WA3Out), 32'(lastWa));
        nextCycle();
        ops.delete();
    endtask

    initial begin
        op_t o;
        Reset = 1'b0;
        lastRes = '0;
        lastWa  = '0;
        driveIdle(1'b0);
        StartE = 1'b1;
        #1;
        chk("rst_stall", 32'(StallReq), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        nextCycle();
        nextCycle();
        chk("rst_result", Result, 32'd0);
        chk("rst_wa", 32'(WA3Out), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        Reset = 1'b1;
        driveIdle(1'b0);
        nextCycle();

        // MUL 7x6 -> 42
        ops.push_back(mk(1'b0, 32'd7, 32'd6, 32'hDEAD, 4'd3));
        runChain(1'b0);

        // MLA wrap: 0xFFFFFFFF*2 + 5 -> 3; kill during DONE is ignored
        ops.push_back(mk(1'b1, 32'hFFFF_FFFF, 32'd2, 32'd5, 4'd9));
        runChain(1'b1);

        // Back-to-back 7x6 then 3x3
        ops.push_back(mk(1'b0, 32'd7, 32'd6, 32'd0, 4'd1));
        ops.push_back(mk(1'b0, 32'd3, 32'd3, 32'd0, 4'd2));
        runChain(1'b0);

        // Early-termination shaped operand and zero multiplier
        ops.push_back(mk(1'b0, 32'd5, 32'd3, 32'd0, 4'd4));
        ops.push_back(mk(1'b1, 32'd123, 32'd0, 32'd77, 4'd5));
        runChain(1'b0);

        // Random chains of mixed MUL/MLA
        for (int r = 0; r < 6; r++) begin
            for (int j = 0; j < 1 + (r % 3); j++) begin
                o = mk(1'($urandom), $urandom, (r[0]) ? 32'($urandom_range(0, 255)) : $urandom,
                       $urandom, 4'($urandom));
                ops.push_back(o);
            end
            runChain(1'b0);
        end

        // StartE with KillE in IDLE starts nothing
        o = mk(1'b0, 32'd9, 32'd9, 32'd0, 4'd7);
        drive(1'b1, 1'b1, o);
        chk("sk_stall", 32'(StallReq), 32'd0);
        nextCycle();
        driveIdle(1'b0);
        chk("sk_busy", 32'(Busy), 32'd0);
        chk("sk_stall_after", 32'(StallReq), 32'd0);
        nextCycle();

        // Kill at RUN cycle 10
        o = mk(1'b0, 32'd1234, 32'hFFFF_FFFF, 32'd0, 4'd6);
        drive(1'b1, 1'b0, o);
        nextCycle();
        for (int c = 1; c < 10; c++) begin
            driveIdle(1'b0);
            nextCycle();
        end
        driveIdle(1'b1);
        chk("kill_stall", 32'(StallReq), 32'd0);
        chk("kill_busy", 32'(Busy), 32'd1);
        nextCycle();
        for (int c = 0; c < 40; c++) begin
            driveIdle(1'b0);
            chk("kill_idle_busy", 32'(Busy), 32'd0);
            chk("kill_no_done", 32'(Done), 32'd0);
            if (c == 0) begin
                chk("kill_stall_after", 32'(StallReq), 32'd0);
                chk("kill_result_hold", Result, lastRes);
                chk("kill_wa_hold", 32'(WA3Out), 32'(lastWa));
            end
            nextCycle();
        end

        // Reset asserted at RUN cycle 5
        o = mk(1'b0, 32'd11, 32'd13, 32'd0, 4'd8);
        drive(1'b1, 1'b0, o);
        nextCycle();
        for (int c = 1; c < 5; c++) begin
            driveIdle(1'b0);
            nextCycle();
        end
        Reset = 1'b0;
        driveIdle(1'b0);
        chk("mrst_stall", 32'(StallReq), 32'd0);
        chk("mrst_busy", 32'(Busy), 32'd0);
        chk("mrst_done", 32'(Done), 32'd0);
        nextCycle();
        chk("mrst_result", Result, 32'd0);
        chk("mrst_wa", 32'(WA3Out), 32'd0);
        Reset = 1'b1;
        driveIdle(1'b0);
        chk("mrst_idle_busy", 32'(Busy), 32'd0);
        chk("mrst_idle_stall", 32'(StallReq), 32'd0);
        lastRes = '0;
        lastWa  = '0;
        nextCycle();

        // Normal operation after reset
        ops.push_back(mk(1'b1, 32'd100, 32'd200, 32'd1, 4'd15));
        runChain(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_sequencer.md
MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning operand/result width.
REQ-002 SHALL have parameter CNT_W, default $clog2(DATA_W)+1, meaning iteration counter width.
REQ-003 SHALL have port Clk  input  1  rising-edge clock.
REQ-004 SHALL have port Reset  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port StartE  input  1  MUL/MLA valid in Execute stage.
REQ-006 SHALL have port OpE  input  1  0=MUL, 1=MLA (accumulate).
REQ-007 SHALL have port SrcAE  input  DATA_W  multiplicand.
REQ-008 SHALL have port SrcBE  input  DATA_W  multiplier.
REQ-009 SHALL have port AccE  input  DATA_W  accumulate operand (MLA only).
REQ-010 SHALL have port WA3E  input  4  destination register.
REQ-011 SHALL have port KillE  input  1  flush/abort from branch or flush logic.
REQ-012 SHALL have port StallReq  output  1  stall request to F, D, E stages.
REQ-013 SHALL have port Busy  output  1  high in RUN.
REQ-014 SHALL have port Done  output  1  one-cycle result-valid pulse.
REQ-015 SHALL have port Result  output  DATA_W  low DATA_W bits of product (+Acc).
REQ-016 SHALL have port WA3Out  output  4  destination of Result.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE.
REQ-018 IDLE with StartE=1 and KillE=0 SHALL latch SrcAE, SrcBE, WA3E, and product = OpE ? AccE : 0, clear counter, go to RUN.
REQ-019 StartE and KillE both high SHALL start nothing; state stays IDLE.
REQ-020 Each RUN cycle: if multiplier LSB=1, product += multiplicand (mod 2^DATA_W); multiplicand <<= 1; multiplier >>= 1; counter += 1.
REQ-021 RUN SHALL go to DONE when counter reaches DATA_W (DATA_W RUN cycles).
REQ-022 KillE=1 in RUN SHALL go to IDLE next cycle, discard product, no Done.
REQ-023 DONE SHALL drive Done=1, Result=product, WA3Out=latched WA3 for exactly that cycle; KillE in DONE ignored.
REQ-024 DONE with StartE=1, KillE=0 SHALL reload per REQ-018 and go to RUN (back-to-back); else go to IDLE.
REQ-025 StallReq SHALL be combinational: (StartE & ~KillE & state!=RUN) | (state==RUN & ~KillE).
REQ-026 Latency: StartE at cycle N -> Done at cycle N+DATA_W+1 (N+33 for DATA_W=32).
REQ-027 Result and WA3Out SHALL hold last values outside DONE; Done=0 outside DONE.

Reset
REQ-028 Reset=0 at a rising edge SHALL force IDLE, counter 0, product/Result 0, WA3Out 0, regardless of state (including mid-RUN).
REQ-029 During Reset=0, StallReq, Busy, Done SHALL be 0.

Configuration
REQ-030 Macro MULSEQ_EARLY_TERM_EN defined: RUN SHALL go to DONE after the first iteration whose shifted multiplier is zero (minimum 1 RUN cycle).
REQ-031 Macro undefined: RUN SHALL always run exactly DATA_W cycles; results identical in both builds.

Structure
REQ-032 Package mulseq_pkg SHALL hold state enum (IDLE, RUN, DONE), op encoding constants OP_MUL/OP_MLA, default DATA_W.
REQ-033 Shift/add registers SHALL be in one sub-module mulseq_datapath; FSM, counter, stall logic in mul_sequencer.

Verification
REQ-034 MUL 7x6, WA3E=3, no macro -> StallReq high N..N+32, Done at N+33, Result=42, WA3Out=3.
REQ-035 MLA 0xFFFFFFFF x 2 + 5 -> Result=0x00000003 (wrap), Done at N+33.
REQ-036 KillE at RUN cycle 10 -> IDLE next cycle, no Done, StallReq low, Result unchanged.
REQ-037 Reset=0 at RUN cycle 5 -> next cycle IDLE, all outputs 0; StartE+KillE same cycle -> no start.
REQ-038 Back-to-back: StartE held in DONE with 3x3 after 7x6 -> Done=42 then Done=9 at +33 cycles, no IDLE gap.
REQ-039 With MULSEQ_EARLY_TERM_EN, MUL 5x3 -> 2 RUN cycles, Done at N+3, Result=15.
